// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: word width, instruction class codes, MEM-stage FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mips_pipe_pkg;

  localparam int WORD_W = 32;

  // Instruction class codes carried down the pipe in the type* registers.
  localparam logic [2:0] CLS_RR_ALU = 3'b000;
  localparam logic [2:0] CLS_RI_ALU = 3'b001;
  localparam logic [2:0] CLS_LOAD   = 3'b010;
  localparam logic [2:0] CLS_STORE  = 3'b011;
  localparam logic [2:0] CLS_BRANCH = 3'b100;
  localparam logic [2:0] CLS_HALT   = 3'b101;
  localparam logic [2:0] CLS_NOP    = 3'b111;  // bubble, ignored by write-back

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  function automatic logic is_mem_op(input logic [2:0] cls);
    return (cls == CLS_LOAD) || (cls == CLS_STORE);
  endfunction

endpackage

// File: rtl/dmem_handshake.sv
// Data-memory req/ready handshake: IDLE/ACCESS FSM, request registers, stall.
// Latency: request registered on the accept edge; done on the first ACCESS cycle with mem_ready.
// Backpressure: stall is high on the accept cycle and on every ACCESS cycle without mem_ready.
// Ports: start/start_* launch an access from IDLE; mem_* drive the external memory;
//        idle/done tell the stage when it may accept and when the access retires.
module dmem_handshake
  import mips_pipe_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              start_we,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [WORD_W-1:0] start_wdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              stall,
  output logic              idle,
  output logic              done
);

  mem_state_e        state, state_nxt;
  logic              req_nxt, we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [WORD_W-1:0] wdata_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    stall     = 1'b0;
    idle      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        idle = 1'b1;
        // mem_ready is deliberately not looked at here.
        if (start) begin
          stall     = 1'b1;
          state_nxt = ST_ACCESS;
          req_nxt   = 1'b1;
          we_nxt    = start_we;
          addr_nxt  = start_addr;
          wdata_nxt = start_wdata;
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores to data memory and registers the MEM/WB set.
// Latency: 1 cycle for non-memory ops; N+1 for load/store (N = ACCESS cycles up to mem_ready).
// Backpressure: stall (combinational) holds the *34 inputs while an access is pending.
// Ports: *34 from EX/MEM, branch_f squash, mem_* data-memory handshake,
//        *45 MEM/WB registers, misalign_f sticky misaligned-access flag.
module mem_access_stage
  import mips_pipe_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        type34,
  input  logic [WORD_W-1:0] ALUout34,
  input  logic [WORD_W-1:0] B34,
  input  logic [WORD_W-1:0] INS34,
  input  logic              branch_f,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [WORD_W-1:0] ALUout45,
  output logic [WORD_W-1:0] TLD45,
  output logic [WORD_W-1:0] INS45,
  output logic [2:0]        type45,
  output logic              misalign_f
);

  logic              halted;
  logic              effective;
  logic              is_mem;
  logic              start;
  logic              hs_idle;
  logic              hs_done;
  logic [ADDR_W-1:0] aligned_addr;

  // Instruction parked while its memory access is in flight.
  logic [WORD_W-1:0] lat_alu;
  logic [WORD_W-1:0] lat_ins;
  logic [2:0]        lat_type;

  assign effective    = !branch_f && !halted;
  assign is_mem       = is_mem_op(type34);
  assign start        = hs_idle && effective && is_mem;
  assign aligned_addr = {ALUout34[ADDR_W-1:2], 2'b00};

  dmem_handshake #(
    .ADDR_W (ADDR_W)
  ) u_dmem_handshake (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_we    (type34 == CLS_STORE),
    .start_addr  (aligned_addr),
    .start_wdata (B34),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .stall       (stall),
    .idle        (hs_idle),
    .done        (hs_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUout45   <= '0;
      TLD45      <= '0;
      INS45      <= '0;
      type45     <= CLS_NOP;
      halted     <= 1'b0;
      misalign_f <= 1'b0;
      lat_alu    <= '0;
      lat_ins    <= '0;
      lat_type   <= CLS_NOP;
    end else begin
      // type45 is a one-cycle strobe per real instruction; bubble otherwise.
      type45 <= CLS_NOP;
      if (hs_idle) begin
        if (start) begin
          lat_alu  <= ALUout34;
          lat_ins  <= INS34;
          lat_type <= type34;
          if (ALUout34[1:0] != 2'b00) begin
            misalign_f <= 1'b1;
          end
        end else if (effective && (type34 != CLS_NOP)) begin
          ALUout45 <= ALUout34;
          INS45    <= INS34;
          type45   <= type34;
          TLD45    <= '0;
          if (type34 == CLS_HALT) begin
            halted <= 1'b1;
          end
        end
      end else if (hs_done) begin
        ALUout45 <= lat_alu;
        INS45    <= lat_ins;
        type45   <= lat_type;
        TLD45    <= (lat_type == CLS_LOAD) ? mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mips_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  type34;
  logic [31:0] ALUout34;
  logic [31:0] B34;
  logic [31:0] INS34;
  logic        branch_f;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] ALUout45;
  logic [31:0] TLD45;
  logic [31:0] INS45;
  logic [2:0]  type45;
  logic        misalign_f;

  int n_vec  = 0;
  int n_miss = 0;
  int stall_cycles;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .type34     (type34),
    .ALUout34   (ALUout34),
    .B34        (B34),
    .INS34      (INS34),
    .branch_f   (branch_f),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .ALUout45   (ALUout45),
    .TLD45      (TLD45),
    .INS45      (INS45),
    .type45     (type45),
    .misalign_f (misalign_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ins);
    type34   = t;
    ALUout34 = a;
    B34      = b;
    INS34    = ins;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_req",      32'(mem_req),    32'd0);
    chk("rst_we",       32'(mem_we),     32'd0);
    chk("rst_addr",     mem_addr,        32'd0);
    chk("rst_wdata",    mem_wdata,       32'd0);
    chk("rst_alu45",    ALUout45,        32'd0);
    chk("rst_tld45",    TLD45,           32'd0);
    chk("rst_ins45",    INS45,           32'd0);
    chk("rst_type45",   32'(type45),     32'd7);
    chk("rst_misalign", 32'(misalign_f), 32'd0);
    chk("rst_stall",    32'(stall),      32'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    branch_f  = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    set_ins(CLS_NOP, 32'd0, 32'd0, 32'd0);
    #3;
    do_reset();
    tick();

    // rr_alu pass-through, one cycle
    set_ins(CLS_RR_ALU, 32'h0000_0005, 32'd0, 32'h0123_4567);
    tick();
    chk("alu_out45",  ALUout45,    32'h5);
    chk("alu_type45", 32'(type45), 32'd0);
    chk("alu_ins45",  INS45,       32'h0123_4567);
    set_ins(CLS_NOP, 32'd0, 32'd0, 32'd0);
    tick();
    chk("nop_type45", 32'(type45), 32'd7);
    chk("nop_hold",   ALUout45,    32'h5);

    // load 0x100, ready on third ACCESS cycle
    stall_cycles = 0;
    set_ins(CLS_LOAD, 32'h0000_0100, 32'h1111_1111, 32'h8C00_0100);
    #1;
    chk("ld_stall_accept", 32'(stall), 32'd1);
    if (stall) stall_cycles++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("ld_req",   32'(mem_req), 32'd1);
      chk("ld_addr",  mem_addr,     32'h100);
      chk("ld_we",    32'(mem_we),  32'd0);
      chk("ld_type45_wait", 32'(type45), 32'd7);
      if (i == 3) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
      #1;
      if (stall) stall_cycles++;
    end
    chk("ld_stall_cycles", 32'(stall_cycles), 32'd3);
    set_ins(CLS_NOP, 32'd0, 32'd0, 32'd0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    chk("ld_tld45",   TLD45,        32'hDEAD_BEEF);
    chk("ld_type45",  32'(type45),  32'd2);
    chk("ld_alu45",   ALUout45,     32'h100);
    chk("ld_ins45",   INS45,        32'h8C00_0100);
    chk("ld_req_off", 32'(mem_req), 32'd0);
    tick();
    chk("ld_type45_once", 32'(type45), 32'd7);

    // store 0xCAFEF00D to 0x204, immediate ready
    set_ins(CLS_STORE, 32'h0000_0204, 32'hCAFE_F00D, 32'hAC00_0204);
    #1;
    chk("st_stall_accept", 32'(stall), 32'd1);
    tick();
    chk("st_req",   32'(mem_req), 32'd1);
    chk("st_we",    32'(mem_we),  32'd1);
    chk("st_wdata", mem_wdata,    32'hCAFE_F00D);
    chk("st_addr",  mem_addr,     32'h204);
    mem_ready = 1'b1;
    #1;
    chk("st_stall_ready", 32'(stall), 32'd0);
    set_ins(CLS_NOP, 32'd0, 32'd0, 32'd0);
    tick();
    mem_ready = 1'b0;
    chk("st_type45", 32'(type45), 32'd3);
    chk("st_tld45",  TLD45,       32'd0);
    chk("st_we_off", 32'(mem_we), 32'd0);

    // misaligned load 0x102
    set_ins(CLS_LOAD, 32'h0000_0102, 32'd0, 32'h8C00_0102);
    tick();
    chk("mis_addr", mem_addr,        32'h100);
    chk("mis_flag", 32'(misalign_f), 32'd1);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0042;
    #1;
    set_ins(CLS_NOP, 32'd0, 32'd0, 32'd0);
    tick();
    mem_ready = 1'b0;
    chk("mis_type45", 32'(type45), 32'd2);
    chk("mis_tld45",  TLD45,       32'h42);
    tick();
    chk("mis_sticky", 32'(misalign_f), 32'd1);

    // squashed load
    branch_f = 1'b1;
    set_ins(CLS_LOAD, 32'h0000_0300, 32'd0, 32'h8C00_0300);
    #1;
    chk("sq_stall", 32'(stall), 32'd0);
    tick();
    chk("sq_req",    32'(mem_req), 32'd0);
    chk("sq_type45", 32'(type45),  32'd7);
    branch_f = 1'b0;

    // halt, then store and alu op: nothing gets through
    set_ins(CLS_HALT, 32'd0, 32'd0, 32'hFFFF_0000);
    tick();
    chk("halt_type45", 32'(type45), 32'd5);
    set_ins(CLS_STORE, 32'h0000_0400, 32'h1234_5678, 32'hAC00_0400);
    #1;
    chk("halt_st_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_st_req",    32'(mem_req), 32'd0);
      chk("halt_st_type45", 32'(type45),  32'd7);
    end
    set_ins(CLS_RR_ALU, 32'h0000_0099, 32'd0, 32'd0);
    tick();
    chk("halt_alu_type45", 32'(type45), 32'd7);

    // reset clears halted/misalign; then reset during ACCESS
    set_ins(CLS_NOP, 32'd0, 32'd0, 32'd0);
    do_reset();
    tick();
    set_ins(CLS_LOAD, 32'h0000_0300, 32'd0, 32'h8C00_0300);
    tick();
    chk("ar_req_up", 32'(mem_req), 32'd1);
    set_ins(CLS_NOP, 32'd0, 32'd0, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("ar_req_drop", 32'(mem_req), 32'd0);
    chk("ar_stall",    32'(stall),   32'd0);
    #1 rst = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ready = 1'b0;
    chk("ar_type45", 32'(type45), 32'd7);
    chk("ar_tld45",  TLD45,       32'd0);
    chk("ar_alu45",  ALUout45,    32'd0);
    chk("ar_req",    32'(mem_req), 32'd0);

    // after reset the stage works again
    set_ins(CLS_RI_ALU, 32'h0000_0077, 32'd0, 32'h2000_0077);
    tick();
    chk("post_type45", 32'(type45), 32'd1);
    chk("post_alu45",  ALUout45,    32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
